// File: rtl/prbs_pkg.sv
// prbs_pkg: shared FSM encoding, counter width and PRBS tap/popcount width helpers
package prbs_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_HUNT, S_LOCKED} state_t;
  localparam int CNT_W = 32;
  function automatic int prbs_tap(input int order);
    return order == 7 ? 6 : order == 15 ? 14 : order == 23 ? 18 : 28;
  endfunction
  function automatic int pc_w(input int dw);
    return $clog2(dw + 1);
  endfunction
endpackage

// File: rtl/prbs_popcount.sv
// prbs_popcount: combinational population count of the error mask
module prbs_popcount import prbs_pkg::*; #(
  parameter int DW = 32,
  localparam int PW = pc_w(DW)
) (
  input  logic [DW-1:0] i_mask,
  output logic [PW-1:0] o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < DW; i++) o_cnt = o_cnt + PW'(i_mask[i]);
  end
endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS-7/15/23/31 receive checker with lock FSM and BER counters
module prbs_checker import prbs_pkg::*; #(
  parameter int DW = 32,
  parameter int PRBS = 31,
  parameter int LOCK_CNT = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prbs_chk_en,
  input  logic [DW-1:0]    rx_data,
  input  logic             rx_valid,
  input  logic             err_clr,
  output logic             prbs_lock,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
);
  localparam int TAP = prbs_tap(PRBS);
  localparam int PW = pc_w(DW);
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);
  state_t           r_state;
  logic [PRBS-1:0]  r_hist, r_s1_prev;
  logic [DW-1:0]    r_s1_cur;
  logic             r_hist_ok, r_s1_v, r_s2_v, r_s2_err, r_sticky;
  logic [PW-1:0]    r_s2_pop;
  logic [LW-1:0]    r_clean;
  logic [UW-1:0]    r_bad;
  logic [CNT_W-1:0] r_err_cnt, r_word_cnt;
  logic [DW+PRBS-1:0] w_s;
  logic [DW-1:0]    w_mask;
  logic [PW-1:0]    w_pop;
  logic [CNT_W:0]   w_err_sum;
  logic             w_lk_ev;
  // only the newest PRBS bits of the previous word can reach the current word's taps
  assign w_s = {r_s1_cur, r_s1_prev};
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DW; i++) w_mask[i] = r_s1_cur[i] ^ w_s[i] ^ w_s[i+PRBS-TAP];
  end
  prbs_popcount #(.DW(DW)) u_pop (.i_mask(w_mask), .o_cnt(w_pop));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_hist    <= '0;
      r_hist_ok <= 1'b0;
      r_s1_cur  <= '0;
      r_s1_prev <= '0;
      r_s1_v    <= 1'b0;
      r_s2_pop  <= '0;
      r_s2_err  <= 1'b0;
      r_s2_v    <= 1'b0;
    end else begin
      r_s1_v    <= prbs_chk_en && rx_valid && r_hist_ok;
      r_s2_v    <= prbs_chk_en && r_s1_v;
      r_hist_ok <= prbs_chk_en && (r_hist_ok || rx_valid);
      if (prbs_chk_en && rx_valid) begin
        r_hist    <= rx_data[DW-1 -: PRBS];
        r_s1_cur  <= rx_data;
        r_s1_prev <= r_hist;
      end
      if (r_s1_v) begin
        r_s2_pop <= w_pop;
        r_s2_err <= |w_mask;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_clean <= '0;
      r_bad   <= '0;
    end else if (!prbs_chk_en) begin
      r_state <= S_IDLE;
      r_clean <= '0;
      r_bad   <= '0;
    end else case (r_state)
      S_IDLE:   r_state <= S_PRIME;
      S_PRIME:  if (r_hist_ok) r_state <= S_HUNT;
      S_HUNT:   if (r_s2_v) begin
        if (r_s2_err) r_clean <= '0;
        else if (r_clean == LW'(LOCK_CNT - 1)) begin
          r_state <= S_LOCKED;
          r_bad   <= '0;
        end else r_clean <= r_clean + LW'(1);
      end
      S_LOCKED: if (r_s2_v) begin
        if (!r_s2_err) r_bad <= '0;
        else if (r_bad == UW'(UNLOCK_CNT - 1)) begin
          r_state <= S_HUNT;
          r_clean <= '0;
        end else r_bad <= r_bad + UW'(1);
      end
      default:  r_state <= S_IDLE;
    endcase
  assign w_lk_ev   = prbs_chk_en && r_s2_v && r_state == S_LOCKED;
  assign w_err_sum = {1'b0, r_err_cnt} + (CNT_W+1)'(r_s2_pop);
  always_ff @(posedge clk or posedge rst)
    if (rst || err_clr) begin
      r_err_cnt  <= '0;
      r_word_cnt <= '0;
      r_sticky   <= 1'b0;
    end else if (w_lk_ev) begin
      r_err_cnt  <= w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
      r_word_cnt <= &r_word_cnt ? r_word_cnt : r_word_cnt + CNT_W'(1);
      r_sticky   <= r_sticky | r_s2_err;
    end
  assign prbs_lock  = r_state == S_LOCKED;
  assign err_sticky = r_sticky;
  assign err_cnt    = r_err_cnt;
  assign word_cnt   = r_word_cnt;
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed scoreboard bench for prbs_checker (PRBS-31, 32-bit words)
module tb_prbs_checker;
  localparam int L = 0, S = 1, E = 2, W = 3;
  logic        clk = 1'b0, rst = 1'b1, prbs_chk_en = 1'b1, rx_valid = 1'b0, err_clr = 1'b0;
  logic [31:0] rx_data = '0;
  logic        prbs_lock, err_sticky;
  logic [31:0] err_cnt, word_cnt;
  int          q_at[$], q_sel[$];
  logic [31:0] q_val[$];
  int          edge_n = 0, last_e = 0, n_chk = 0, n_pass = 0;
  logic [30:0] h = 31'h2C9B_7E15;
  logic [15:0] pat = 16'b1011_0010_1110_0101;
  logic [31:0] act;

  prbs_checker dut (
    .clk(clk), .rst(rst), .prbs_chk_en(prbs_chk_en), .rx_data(rx_data),
    .rx_valid(rx_valid), .err_clr(err_clr), .prbs_lock(prbs_lock),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  function automatic string sname(input int sel);
    return sel == L ? "prbs_lock" : sel == S ? "err_sticky" : sel == E ? "err_cnt" : "word_cnt";
  endfunction
  function automatic logic [31:0] pick(input int sel);
    return sel == L ? {31'b0, prbs_lock} : sel == S ? {31'b0, err_sticky} : sel == E ? err_cnt : word_cnt;
  endfunction
  // PRBS-31 transmitter: b[n] = b[n-31] ^ b[n-28], bit 0 sent first
  function automatic logic [31:0] next_word();
    logic [31:0] w;
    logic b;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      b = h[30] ^ h[27];
      w[i] = b;
      h = {h[29:0], b};
    end
    return w;
  endfunction
  task automatic expect_at(input int at, input int sel, input logic [31:0] v);
    q_at.push_back(at);
    q_sel.push_back(sel);
    q_val.push_back(v);
  endtask
  task automatic send(input logic [31:0] flip, input logic v);
    if (v) rx_data = next_word() ^ flip;
    rx_valid = v;
    @(posedge clk);
    #1 last_e = edge_n;
  endtask

  always @(negedge clk)
    for (int i = q_at.size() - 1; i >= 0; i--)
      if (q_at[i] <= edge_n) begin
        act = pick(q_sel[i]);
        n_chk++;
        if (q_at[i] < edge_n)
          $display("FAIL %s@%0d: slot missed at edge %0d, want %h", sname(q_sel[i]), q_at[i], edge_n, q_val[i]);
        else if (act !== q_val[i])
          $display("FAIL %s@%0d: got %h want %h", sname(q_sel[i]), q_at[i], act, q_val[i]);
        else n_pass++;
        q_at.delete(i);
        q_sel.delete(i);
        q_val.delete(i);
      end

  initial begin
    int e;
    @(posedge clk);
    #1;
    expect_at(edge_n, L, 0);
    expect_at(edge_n, S, 0);
    expect_at(edge_n, E, 0);
    expect_at(edge_n, W, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    // clean lock: word 0 primes, words 1..16 reach lock two edges after word 16
    send(0, 1);
    e = last_e;
    expect_at(e + 17, L, 0);
    expect_at(e + 18, L, 1);
    expect_at(e + 18, E, 0);
    expect_at(e + 18, W, 0);
    expect_at(e + 19, W, 1);
    for (int k = 1; k <= 24; k++) send(0, 1);
    expect_at(last_e + 2, W, 8);
    // single line-bit flip gives mask bits 5, 33, 36 across two words
    send(32'h20, 1);
    e = last_e;
    expect_at(e + 1, S, 0);
    expect_at(e + 2, S, 1);
    expect_at(e + 2, E, 1);
    expect_at(e + 3, E, 3);
    for (int k = 0; k < 4; k++) send(0, 1);
    expect_at(last_e + 2, L, 1);
    expect_at(last_e + 2, W, 13);
    expect_at(last_e + 2, E, 3);
    // bit-0 flips stay within their own word: 3 errors each
    for (int k = 0; k < 4; k++) send(32'h1, 1);
    expect_at(last_e + 1, L, 1);
    expect_at(last_e + 2, L, 0);
    expect_at(last_e + 2, E, 15);
    expect_at(last_e + 2, W, 17);
    for (int k = 0; k < 16; k++) send(0, 1);
    expect_at(last_e + 1, L, 0);
    expect_at(last_e + 2, L, 1);
    expect_at(last_e + 2, W, 17);
    expect_at(last_e + 2, E, 15);
    // valid gaps while locked: 9 valid words in the pattern
    for (int k = 15; k >= 0; k--) send(0, pat[k]);
    send(0, 0);
    send(0, 0);
    expect_at(last_e, L, 1);
    expect_at(last_e, W, 26);
    expect_at(last_e, E, 15);
    // one-cycle disable: idle at once, counters held, full prime and hunt again
    prbs_chk_en = 1'b0;
    send(0, 1);
    prbs_chk_en = 1'b1;
    expect_at(last_e, L, 0);
    expect_at(last_e, W, 26);
    expect_at(last_e, E, 15);
    for (int k = 0; k < 17; k++) send(0, 1);
    expect_at(last_e + 1, L, 0);
    expect_at(last_e + 2, L, 1);
    expect_at(last_e + 2, W, 26);
    expect_at(last_e + 2, S, 1);
    // clear lands in the same cycle as an errored word's count
    send(32'h1, 1);
    e = last_e;
    expect_at(e + 1, S, 1);
    expect_at(e + 1, E, 15);
    send(0, 1);
    err_clr = 1'b1;
    send(0, 1);
    err_clr = 1'b0;
    expect_at(e + 2, E, 0);
    expect_at(e + 2, S, 0);
    expect_at(e + 2, W, 0);
    send(0, 1);
    expect_at(e + 3, W, 1);
    expect_at(e + 4, W, 2);
    expect_at(e + 4, L, 1);
    // saturation
    send(0, 0);
    force dut.r_err_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_err_cnt;
    send(0, 1);
    expect_at(last_e + 2, E, 32'hFFFF_FFFE);
    send(32'h1, 1);
    expect_at(last_e + 2, E, 32'hFFFF_FFFF);
    expect_at(last_e + 2, S, 1);
    send(0, 1);
    send(0, 1);
    expect_at(last_e + 2, L, 1);
    expect_at(last_e + 2, E, 32'hFFFF_FFFF);
    send(0, 0);
    send(0, 0);
    // asynchronous reset mid-cycle
    send(0, 1);
    #2 rst = 1'b1;
    expect_at(last_e, L, 0);
    expect_at(last_e, S, 0);
    expect_at(last_e, E, 0);
    expect_at(last_e, W, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < q_at.size(); i++) begin
      n_chk++;
      $display("FAIL %s@%0d: never checked, want %h", sname(q_sel[i]), q_at[i], q_val[i]);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/prbs_checker.md
# prbs_checker

Receive-side PRBS checker that consumes `prbs_chk_en` from the link control block and checks the parallel receive data of the JESD lane for a PRBS-7/15/23/31 pattern. It self-synchronises to the incoming stream, declares lock after a run of clean words and drops lock after a run of errored words. It keeps saturating bit-error and checked-word counters for BER measurement. It sits between the lane deserialiser/aligner and the status register file.

## Interface
Parameters:
- `DW`, 32, data word width; must satisfy `DW >= PRBS`.
- `PRBS`, 31, pattern order: 7, 15, 23 or 31. Taps are (7,6), (15,14), (23,18) and (31,28).
- `LOCK_CNT`, 16, consecutive clean words needed to lock.
- `UNLOCK_CNT`, 4, consecutive errored words needed to drop lock.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `prbs_chk_en`  in  1  checker enable, level.
- `rx_data`  in  DW  received word; bit 0 is the earliest bit in time.
- `rx_valid`  in  1  `rx_data` qualifier.
- `err_clr`  in  1  single-cycle pulse; clears counters and the sticky flag.
- `prbs_lock`  out  1  high in state LOCKED.
- `err_sticky`  out  1  set on any bit error while LOCKED.
- `err_cnt`  out  32  saturating count of bit errors.
- `word_cnt`  out  32  saturating count of words checked while LOCKED.

## Operation
- Self-synchronous check: `exp[i] = s[i-PRBS] ^ s[i-TAP]`, where `s` is {current word, previous valid word} and bit i is the current word's bit i. The error mask is `rx_data ^ exp`.
- Because of self-synchronisation, one flipped line bit produces up to 3 mask bits (at i, i+TAP, i+PRBS), which may span two words. This is the intended behaviour.
- FSM states: IDLE, PRIME, HUNT, LOCKED.
  - IDLE → PRIME when `prbs_chk_en` = 1.
  - PRIME → HUNT on the first valid word. That word only loads the history register and is never checked.
  - HUNT: a clean word increments `clean_cnt`; an errored word zeroes it. When `clean_cnt` reaches `LOCK_CNT`, go to LOCKED and zero `bad_cnt`.
  - LOCKED: an errored word increments `bad_cnt`; a clean word zeroes it. When `bad_cnt` reaches `UNLOCK_CNT`, go to HUNT and zero `clean_cnt`.
  - Any state → IDLE when `prbs_chk_en` = 0. This also invalidates the history register. Counters and `err_sticky` hold their values.
- Counting applies only to words whose check result is evaluated in LOCKED, including the word that causes unlock:
  - `err_cnt += popcount(mask)`.
  - `word_cnt += 1`.
  - Both saturate at 0xFFFF_FFFF. Add at full width, then clamp.
- `err_clr` zeroes `err_cnt`, `word_cnt` and `err_sticky`. If an increment or sticky set happens in the same cycle, the clear wins and the result is 0.
- Cycles with `rx_valid` = 0 are ignored. The pipeline and history hold.
- Reset: state IDLE; all counters, outputs and internal registers are 0.

## Timing
- Stage 1: a word sampled at edge k is registered with its history.
- Stage 2: the mask and popcount are registered at edge k+1.
- Stage 3: FSM, `prbs_lock`, `err_sticky` and the counters update at edge k+2. Total latency from sample to outputs is 2 cycles.
- Full throughput of one word per cycle; no backpressure.
- `prbs_chk_en` falling at edge k:
  - the FSM is IDLE after edge k;
  - `prbs_lock` drops the same cycle;
  - in-flight stage-2 results are discarded.
- The `rst` assertion takes effect immediately, mid-word included. Deassertion is synchronised externally.

## Structure
- Package `prbs_pkg` holds:
  - the FSM state enum;
  - the `PRBS`-to-`TAP` constant function;
  - the `CNT_W` = 32 constant;
  - the popcount width `$clog2(DW+1)`.
- Sub-module `prbs_popcount` is a pipelined-friendly combinational popcount of the `DW`-bit mask, instantiated once in stage 2.

## Test plan
- Clean lock (`PRBS` = 31, `DW` = 32, `rx_valid` continuous from edge 0, enable already high):
  - word 0 primes the history;
  - `prbs_lock` = 1 after edge 18;
  - `err_cnt` = 0;
  - `word_cnt` counts from then on.
- Single-bit error: while locked, flip bit 5 of one word → `err_cnt` = 3, `err_sticky` = 1, `prbs_lock` stays 1.
- Unlock/relock: corrupt 4 consecutive words → `prbs_lock` = 0 two cycles after the 4th word; then send 16 clean words → relock.
- Gaps and disable:
  - toggling `rx_valid` randomly while locked → no errors and no unlock;
  - `prbs_chk_en` = 0 for one cycle → IDLE with counters retained; the full prime and hunt sequence repeats.
- Clear priority: assert `err_clr` in the same cycle an errored word's count lands → `err_cnt` = 0 and `err_sticky` = 0.
- Saturation and reset:
  - preload `err_cnt` via force to 0xFFFF_FFFE, inject 3 errors → 0xFFFF_FFFF;
  - assert `rst` mid-stream → all outputs 0 immediately.
